axi4_rd_arbiter: RTL and testbench

- Shares one downstream AXI4 read port between NUM_REQ upstream read requesters, such as DMA read channels.
- AR channel: round-robin arbitration, with the grant locked until the AR handshake completes.
- R channel: beats are routed back to the owning requester using an in-order issue-tracking FIFO.
- Sits between the DMA read engines and the memory-side AXI4ReadIntf.

---
 rtl/axi4_rd_arbiter_pkg.sv | 34 +++
 rtl/axi4_rd_arbiter_if.sv | 22 ++
 rtl/axi4_rd_order_fifo.sv | 56 +++++
 rtl/axi4_rd_arbiter.sv | 121 ++++++++++++
 tb/tb_axi4_rd_arbiter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_rd_arbiter_pkg.sv
// Shared AXI4 read-channel types and helpers for the read arbiter slice.
package axi4_rd_arbiter_pkg;

  localparam int MAX_NUM_REQ = 16;
  localparam int REQ_IDX_W   = $clog2(MAX_NUM_REQ);

  typedef logic [REQ_IDX_W-1:0] ReqIdx_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } AxiRdAddr_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } AxiRdData_t;

  typedef enum logic {
    ARB_OPEN,
    ARB_LOCKED
  } ArbState_t;

  // Index width for n requesters, never narrower than one bit.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi4_rd_arbiter_if.sv
// AXI4 read port (AR + R channels) as seen by a requester or a memory.
interface AXI4ReadIntf;
  import axi4_rd_arbiter_pkg::*;

  logic       RdAddrValid;
  logic       RdAddrReady;
  AxiRdAddr_t RdAddrPayload;
  logic       RdDataValid;
  logic       RdDataReady;
  AxiRdData_t RdDataPayload;

  modport Master (
    output RdAddrValid, RdAddrPayload, RdDataReady,
    input  RdAddrReady, RdDataValid, RdDataPayload
  );

  modport Slave (
    input  RdAddrValid, RdAddrPayload, RdDataReady,
    output RdAddrReady, RdDataValid, RdDataPayload
  );

endinterface

// File: rtl/axi4_rd_order_fifo.sv
// Small in-order FIFO recording which requester owns each issued burst.
module axi4_rd_order_fifo
  import axi4_rd_arbiter_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       pushData,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [WIDTH-1:0]       head
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wrPtr_reg;
  logic [PTR_W:0]   rdPtr_reg;
  logic             doPush;
  logic             doPop;

  // Extra MSB on each pointer tells full apart from empty.
  assign count  = wrPtr_reg - rdPtr_reg;
  assign empty  = (wrPtr_reg == rdPtr_reg);
  assign full   = (wrPtr_reg[PTR_W] != rdPtr_reg[PTR_W]) &&
                  (wrPtr_reg[PTR_W-1:0] == rdPtr_reg[PTR_W-1:0]);
  assign doPush = push & ~full;
  assign doPop  = pop & ~empty;
  assign head   = mem[rdPtr_reg[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr_reg[PTR_W-1:0]] <= pushData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_reg <= '0;
      rdPtr_reg <= '0;
    end else begin
      if (doPush) begin
        wrPtr_reg <= wrPtr_reg + 1'b1;
      end
      if (doPop) begin
        rdPtr_reg <= rdPtr_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi4_rd_arbiter.sv
// Round-robin AR arbiter sharing one AXI4 read port; R beats return to the
// owning requester via an in-order owner FIFO.
module axi4_rd_arbiter
  import axi4_rd_arbiter_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  AXI4ReadIntf.Slave                       Req [NUM_REQ],
  AXI4ReadIntf.Master                      Mem,
  output logic                             Busy,
  output logic [$clog2(MAX_OUTSTANDING):0] OutstandingCnt
);

  localparam int IDX_W = idxWidth(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  logic       arValid   [NUM_REQ];
  AxiRdAddr_t arPayload [NUM_REQ];
  logic       rReady    [NUM_REQ];

  ArbState_t  state_reg, state_next;
  ReqIdx_t    ptr_reg, ptr_next;
  ReqIdx_t    sel_reg, sel_next;
  ReqIdx_t    selIdx;
  logic       selValid;
  logic [IDX_W-1:0] cand;

  logic             fifoFull;
  logic             fifoEmpty;
  logic [IDX_W-1:0] headIdx;
  logic [CNT_W-1:0] fifoCount;
  logic             arFire;
  logic             lastFire;
  logic             memRReady;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign arValid[gi]           = Req[gi].RdAddrValid;
      assign arPayload[gi]         = Req[gi].RdAddrPayload;
      assign rReady[gi]            = Req[gi].RdDataReady;
      assign Req[gi].RdAddrReady   = selValid & Mem.RdAddrReady & (selIdx == ReqIdx_t'(gi));
      assign Req[gi].RdDataValid   = ~fifoEmpty & Mem.RdDataValid & (headIdx == IDX_W'(gi));
      assign Req[gi].RdDataPayload = Mem.RdDataPayload;
    end
  endgenerate

  // Descending scan so the candidate closest to ptr_reg wins.
  always_comb begin
    selIdx   = sel_reg;
    selValid = 1'b0;
    cand     = '0;
    if (state_reg == ARB_LOCKED) begin
      selValid = 1'b1;
    end else if (!fifoFull) begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        cand = IDX_W'((int'(ptr_reg) + k) % NUM_REQ);
        if (arValid[cand]) begin
          selIdx   = ReqIdx_t'(cand);
          selValid = 1'b1;
        end
      end
    end
    selValid = selValid & rst_n;
  end

  assign arFire            = selValid & Mem.RdAddrReady;
  assign Mem.RdAddrValid   = selValid;
  assign Mem.RdAddrPayload = arPayload[selIdx[IDX_W-1:0]];

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    ptr_next   = ptr_reg;
    if (arFire) begin
      state_next = ARB_OPEN;
      ptr_next   = (int'(selIdx) + 1 == NUM_REQ) ? '0 : selIdx + 1'b1;
    end else if (selValid) begin
      state_next = ARB_LOCKED;
      sel_next   = selIdx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ARB_OPEN;
      ptr_reg   <= '0;
      sel_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      sel_reg   <= sel_next;
    end
  end

  // An empty FIFO refuses R beats so stray data stalls instead of vanishing.
  assign memRReady       = ~fifoEmpty & rReady[headIdx];
  assign Mem.RdDataReady = memRReady;
  assign lastFire        = Mem.RdDataValid & memRReady & Mem.RdDataPayload.last;

  axi4_rd_order_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (IDX_W)
  ) u_order_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (arFire),
    .pushData (selIdx[IDX_W-1:0]),
    .pop      (lastFire),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount),
    .head     (headIdx)
  );

  assign Busy           = ~fifoEmpty;
  assign OutstandingCnt = fifoCount;

endmodule

// File: tb/tb_axi4_rd_arbiter.sv
// Self-checking bench: directed scenarios plus a randomized run against a
// queue-based model of the arbitration and routing rules.
`timescale 1ns/1ps
module tb_axi4_rd_arbiter;
  import axi4_rd_arbiter_pkg::*;

  localparam int N    = 4;
  localparam int MAXO = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  AXI4ReadIntf reqIf [N] ();
  AXI4ReadIntf memIf ();

  logic                  busy;
  logic [$clog2(MAXO):0] cnt;

  logic       arValid  [N];
  AxiRdAddr_t arPay    [N];
  logic       rReady   [N];
  logic       arReadyO [N];
  logic       rValidO  [N];
  AxiRdData_t rPayO    [N];
  logic       memArReady;
  logic       memRValid;
  AxiRdData_t memRPay;

  int total = 0;
  int bad   = 0;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_tbreq
      assign reqIf[gi].RdAddrValid   = arValid[gi];
      assign reqIf[gi].RdAddrPayload = arPay[gi];
      assign reqIf[gi].RdDataReady   = rReady[gi];
      assign arReadyO[gi]            = reqIf[gi].RdAddrReady;
      assign rValidO[gi]             = reqIf[gi].RdDataValid;
      assign rPayO[gi]               = reqIf[gi].RdDataPayload;
    end
  endgenerate

  assign memIf.RdAddrReady   = memArReady;
  assign memIf.RdDataValid   = memRValid;
  assign memIf.RdDataPayload = memRPay;

  axi4_rd_arbiter #(
    .NUM_REQ         (N),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .Req            (reqIf),
    .Mem            (memIf),
    .Busy           (busy),
    .OutstandingCnt (cnt)
  );

  function automatic AxiRdAddr_t mkAr(input int len);
    AxiRdAddr_t a;
    a.id    = 4'h0;
    a.addr  = $urandom;
    a.len   = 8'(len);
    a.size  = 3'd2;
    a.burst = 2'b01;
    return a;
  endfunction

  function automatic AxiRdData_t mkBeat(input bit last);
    AxiRdData_t d;
    d.id   = 4'h0;
    d.data = $urandom;
    d.resp = 2'b00;
    d.last = last;
    return d;
  endfunction

  // -1: nobody granted, -2: more than one granted.
  function automatic int grantIdx();
    int g;
    g = -1;
    for (int i = 0; i < N; i++) if (arReadyO[i]) g = (g == -1) ? i : -2;
    return g;
  endfunction

  function automatic logic [N-1:0] arVec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = arReadyO[i];
    return v;
  endfunction

  function automatic logic [N-1:0] rvVec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = rValidO[i];
    return v;
  endfunction

  task automatic clearInputs();
    for (int i = 0; i < N; i++) begin
      arValid[i] = 1'b0;
      arPay[i]   = '0;
      rReady[i]  = 1'b1;
    end
    memArReady = 1'b0;
    memRValid  = 1'b0;
    memRPay    = '0;
  endtask

  task automatic doReset();
    clearInputs();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) arValid[i] = 1'b1;
    memArReady = 1'b1;
    memRValid  = 1'b1;
    @(negedge clk);
    total++; if (memIf.RdAddrValid !== 1'b0) begin bad++; $display("FAIL reset_arvalid: got %0b want 0", memIf.RdAddrValid); end
    total++; if (memIf.RdDataReady !== 1'b0) begin bad++; $display("FAIL reset_rready: got %0b want 0", memIf.RdDataReady); end
    total++; if (arVec() !== '0) begin bad++; $display("FAIL reset_req_arready: got %b want 0", arVec()); end
    total++; if (rvVec() !== '0) begin bad++; $display("FAIL reset_req_rvalid: got %b want 0", rvVec()); end
    total++; if (busy !== 1'b0 || cnt !== '0) begin bad++; $display("FAIL reset_busy_cnt: got %0b/%0d want 0/0", busy, cnt); end
    $display("reset checked");
  endtask

  task automatic test_single_ar();
    doReset();
    arValid[2] = 1'b1; arPay[2] = mkAr(3); memArReady = 1'b1;
    memRValid = 1'b1; memRPay = mkBeat(1'b0);
    @(negedge clk);
    total++; if (memIf.RdAddrValid !== 1'b1) begin bad++; $display("FAIL single_arvalid: got %0b want 1", memIf.RdAddrValid); end
    total++; if (memIf.RdAddrPayload !== arPay[2]) begin bad++; $display("FAIL single_payload: got %h want %h", memIf.RdAddrPayload, arPay[2]); end
    total++; if (grantIdx() != 2) begin bad++; $display("FAIL single_grant: got %0d want 2", grantIdx()); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_pre: got %0b want 0", busy); end
    total++; if (memIf.RdDataReady !== 1'b0 || rvVec() !== '0) begin bad++; $display("FAIL stray_beat: got rdy=%0b rv=%b want 0/0", memIf.RdDataReady, rvVec()); end
    $display("AR grant req=2 len=3");
    @(posedge clk); #1;
    arValid[2] = 1'b0; memArReady = 1'b0; memRValid = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b1 || cnt !== 3'd1) begin bad++; $display("FAIL single_busy_post: got %0b/%0d want 1/1", busy, cnt); end
    @(posedge clk); #1;
    for (int b = 0; b < 4; b++) begin
      memRValid = 1'b1; memRPay = mkBeat(b == 3);
      @(negedge clk);
      total++; if (rvVec() !== 4'b0100) begin bad++; $display("FAIL single_beat%0d_route: got %b want 0100", b, rvVec()); end
      total++; if (rPayO[2] !== memRPay || memIf.RdDataReady !== 1'b1) begin bad++; $display("FAIL single_beat%0d_data: got %h/%0b want %h/1", b, rPayO[2], memIf.RdDataReady, memRPay); end
      $display("R beat %0d to req=2 last=%0b", b, memRPay.last);
      @(posedge clk); #1;
    end
    memRValid = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0 || cnt !== '0) begin bad++; $display("FAIL single_done: got %0b/%0d want 0/0", busy, cnt); end
  endtask

  task automatic test_round_robin();
    int expG [7] = '{0, 1, 2, 3, 0, 2, -1};
    int g;
    doReset();
    for (int i = 0; i < N; i++) begin arValid[i] = 1'b1; arPay[i] = mkAr(0); end
    memArReady = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c == 4) begin
        arValid[0] = 1'b1; arPay[0] = mkAr(0);
        arValid[2] = 1'b1; arPay[2] = mkAr(0);
      end
      memRValid = (c >= 1); memRPay = mkBeat(1'b1);
      @(negedge clk);
      g = grantIdx();
      total++; if (g != expG[c]) begin bad++; $display("FAIL rr_grant_c%0d: got %0d want %0d", c, g, expG[c]); end
      if (c >= 1) begin
        total++; if (rvVec() !== 4'(1) << expG[c-1]) begin bad++; $display("FAIL rr_route_c%0d: got %b want req %0d", c, rvVec(), expG[c-1]); end
      end
      $display("RR cycle %0d grant=%0d", c, g);
      @(posedge clk); #1;
      if (expG[c] >= 0) arValid[expG[c]] = 1'b0;
    end
    memRValid = 1'b0;
  endtask

  task automatic test_lock();
    int expL [3] = '{1, 3, 0};
    doReset();
    arValid[1] = 1'b1; arPay[1] = mkAr(2);
    arValid[3] = 1'b1; arPay[3] = mkAr(1);
    for (int c = 0; c < 8; c++) begin
      if (c == 1) begin arValid[0] = 1'b1; arPay[0] = mkAr(0); end
      memArReady = (c >= 5);
      @(negedge clk);
      if (c < 5) begin
        total++; if (memIf.RdAddrValid !== 1'b1 || memIf.RdAddrPayload !== arPay[1]) begin bad++; $display("FAIL lock_hold_c%0d: got %0b/%h want 1/%h", c, memIf.RdAddrValid, memIf.RdAddrPayload, arPay[1]); end
        total++; if (arVec() !== '0) begin bad++; $display("FAIL lock_noready_c%0d: got %b want 0", c, arVec()); end
      end else begin
        total++; if (grantIdx() != expL[c-5]) begin bad++; $display("FAIL lock_grant_c%0d: got %0d want %0d", c, grantIdx(), expL[c-5]); end
        $display("AR grant req=%0d after lock", grantIdx());
      end
      @(posedge clk); #1;
      if (c >= 5) arValid[expL[c-5]] = 1'b0;
    end
  endtask

  task automatic test_full();
    doReset();
    for (int i = 0; i < N; i++) begin arValid[i] = 1'b1; arPay[i] = mkAr(0); end
    memArReady = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++; if (grantIdx() != c) begin bad++; $display("FAIL full_fill_c%0d: got %0d want %0d", c, grantIdx(), c); end
      @(posedge clk); #1;
      arValid[c] = 1'b0;
    end
    arValid[0] = 1'b1; arPay[0] = mkAr(1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (arVec() !== '0 || memIf.RdAddrValid !== 1'b0) begin bad++; $display("FAIL full_block_c%0d: got %b/%0b want 0/0", c, arVec(), memIf.RdAddrValid); end
      total++; if (cnt !== 3'd4) begin bad++; $display("FAIL full_cnt_c%0d: got %0d want 4", c, cnt); end
      @(posedge clk); #1;
    end
    memRValid = 1'b1; memRPay = mkBeat(1'b1);
    @(negedge clk);
    total++; if (arVec() !== '0 || memIf.RdDataReady !== 1'b1 || cnt !== 3'd4) begin bad++; $display("FAIL full_pop_cycle: got ar=%b rdy=%0b cnt=%0d want 0/1/4", arVec(), memIf.RdDataReady, cnt); end
    @(posedge clk); #1;
    memRValid = 1'b0;
    @(negedge clk);
    total++; if (grantIdx() != 0 || memIf.RdAddrPayload !== arPay[0]) begin bad++; $display("FAIL full_resume: got %0d/%h want 0/%h", grantIdx(), memIf.RdAddrPayload, arPay[0]); end
    total++; if (cnt !== 3'd3) begin bad++; $display("FAIL full_cnt_after_pop: got %0d want 3", cnt); end
    $display("AR grant req=0 after FIFO drained one");
    @(posedge clk); #1;
    arValid[0] = 1'b0;
    @(negedge clk);
    total++; if (cnt !== 3'd4) begin bad++; $display("FAIL full_cnt_refill: got %0d want 4", cnt); end
  endtask

  task automatic test_ordering();
    int own [4] = '{3, 3, 0, 0};
    doReset();
    memArReady = 1'b1;
    arValid[3] = 1'b1; arPay[3] = mkAr(1);
    @(negedge clk);
    total++; if (grantIdx() != 3) begin bad++; $display("FAIL order_ar0: got %0d want 3", grantIdx()); end
    @(posedge clk); #1;
    arValid[3] = 1'b0; arValid[0] = 1'b1; arPay[0] = mkAr(1);
    @(negedge clk);
    total++; if (grantIdx() != 0) begin bad++; $display("FAIL order_ar1: got %0d want 0", grantIdx()); end
    @(posedge clk); #1;
    arValid[0] = 1'b0; memArReady = 1'b0;
    for (int b = 0; b < 4; b++) begin
      memRValid = 1'b1; memRPay = mkBeat(b % 2 == 1);
      if (b == 1) begin
        rReady[3] = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          total++; if (memIf.RdDataReady !== 1'b0 || rvVec() !== 4'b1000) begin bad++; $display("FAIL order_stall_s%0d: got rdy=%0b rv=%b want 0/1000", s, memIf.RdDataReady, rvVec()); end
          @(posedge clk); #1;
        end
        rReady[3] = 1'b1;
      end
      @(negedge clk);
      total++; if (rvVec() !== 4'(1) << own[b] || rPayO[own[b]] !== memRPay || memIf.RdDataReady !== 1'b1) begin bad++; $display("FAIL order_beat%0d: got rv=%b rdy=%0b want req %0d", b, rvVec(), memIf.RdDataReady, own[b]); end
      $display("R beat %0d to req=%0d", b, own[b]);
      @(posedge clk); #1;
    end
    memRValid = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL order_done: got %0b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    doReset();
    memArReady = 1'b1;
    arValid[2] = 1'b1; arPay[2] = mkAr(3);
    @(negedge clk);
    total++; if (grantIdx() != 2) begin bad++; $display("FAIL mid_ar: got %0d want 2", grantIdx()); end
    @(posedge clk); #1;
    arValid[2] = 1'b0;
    memRValid = 1'b1; memRPay = mkBeat(1'b0);
    @(negedge clk);
    total++; if (rvVec() !== 4'b0100) begin bad++; $display("FAIL mid_beat0: got %b want 0100", rvVec()); end
    @(posedge clk); #1;
    memRPay = mkBeat(1'b0); arValid[3] = 1'b1; arPay[3] = mkAr(0);
    #2 rst_n = 1'b0;
    #1;
    total++; if (memIf.RdAddrValid !== 1'b0 || memIf.RdDataReady !== 1'b0) begin bad++; $display("FAIL mid_mem_outs: got %0b/%0b want 0/0", memIf.RdAddrValid, memIf.RdDataReady); end
    total++; if (arVec() !== '0 || rvVec() !== '0) begin bad++; $display("FAIL mid_req_outs: got %b/%b want 0/0", arVec(), rvVec()); end
    total++; if (busy !== 1'b0 || cnt !== '0) begin bad++; $display("FAIL mid_busy_cnt: got %0b/%0d want 0/0", busy, cnt); end
    $display("reset asserted during beat 1");
    @(posedge clk); #1;
    rst_n = 1'b1; arValid[3] = 1'b0;
    @(negedge clk);
    total++; if (memIf.RdDataReady !== 1'b0 || rvVec() !== '0) begin bad++; $display("FAIL mid_no_late_beat: got %0b/%b want 0/0", memIf.RdDataReady, rvVec()); end
    @(posedge clk); #1;
    memRValid = 1'b0; arValid[1] = 1'b1; arPay[1] = mkAr(0);
    @(negedge clk);
    total++; if (grantIdx() != 1 || memIf.RdAddrPayload !== arPay[1]) begin bad++; $display("FAIL mid_new_ar: got %0d/%h want 1/%h", grantIdx(), memIf.RdAddrPayload, arPay[1]); end
    @(posedge clk); #1;
    arValid[1] = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b1 || cnt !== 3'd1) begin bad++; $display("FAIL mid_after: got %0b/%0d want 1/1", busy, cnt); end
  endtask

  task automatic test_random();
    int           ownerQ [$];
    int           beatsQ [$];
    int           rrPtr;
    int           locked;
    int           expG;
    int           own;
    bit           arHs;
    bit           rHs;
    logic [N-1:0] expV;
    doReset();
    rrPtr  = 0;
    locked = -1;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!arValid[i] && $urandom_range(0, 2) == 0) begin
          arValid[i] = 1'b1; arPay[i] = mkAr($urandom_range(0, 3));
        end
        rReady[i] = ($urandom_range(0, 3) != 0);
      end
      memArReady = 1'($urandom_range(0, 1));
      if (!memRValid && beatsQ.size() > 0 && $urandom_range(0, 1) == 1) begin
        memRValid = 1'b1; memRPay = mkBeat(beatsQ[0] == 1);
      end
      @(negedge clk);
      expG = -1;
      if (locked >= 0) expG = locked;
      else if (ownerQ.size() < MAXO) begin
        for (int k = 0; k < N; k++) if (expG < 0 && arValid[(rrPtr + k) % N]) expG = (rrPtr + k) % N;
      end
      own = (ownerQ.size() > 0) ? ownerQ[0] : -1;
      total++; if (memIf.RdAddrValid !== (expG >= 0)) begin bad++; $display("FAIL rnd_arvalid_c%0d: got %0b want %0b", c, memIf.RdAddrValid, expG >= 0); end
      if (expG >= 0) begin
        total++; if (memIf.RdAddrPayload !== arPay[expG]) begin bad++; $display("FAIL rnd_payload_c%0d: got %h want %h", c, memIf.RdAddrPayload, arPay[expG]); end
      end
      expV = (expG >= 0 && memArReady) ? 4'(1) << expG : '0;
      total++; if (arVec() !== expV) begin bad++; $display("FAIL rnd_arready_c%0d: got %b want %b", c, arVec(), expV); end
      expV = (own >= 0 && memRValid) ? 4'(1) << own : '0;
      total++; if (rvVec() !== expV) begin bad++; $display("FAIL rnd_rvalid_c%0d: got %b want %b", c, rvVec(), expV); end
      total++; if (memIf.RdDataReady !== (own >= 0 && rReady[own])) begin bad++; $display("FAIL rnd_rready_c%0d: got %0b want %0b", c, memIf.RdDataReady, own >= 0 && rReady[own]); end
      total++; if (busy !== (ownerQ.size() > 0) || int'(cnt) != ownerQ.size()) begin bad++; $display("FAIL rnd_cnt_c%0d: got %0b/%0d want %0b/%0d", c, busy, cnt, ownerQ.size() > 0, ownerQ.size()); end
      arHs = (expG >= 0) && memArReady;
      rHs  = memRValid && (own >= 0) && rReady[own];
      @(posedge clk); #1;
      if (rHs) begin
        memRValid = 1'b0;
        beatsQ[0] = beatsQ[0] - 1;
        if (beatsQ[0] == 0) begin
          void'(beatsQ.pop_front());
          void'(ownerQ.pop_front());
        end
      end
      if (arHs) begin
        ownerQ.push_back(expG);
        beatsQ.push_back(int'(arPay[expG].len) + 1);
        rrPtr  = (expG + 1) % N;
        locked = -1;
        arValid[expG] = 1'b0;
        $display("RND cycle %0d AR grant req=%0d len=%0d", c, expG, arPay[expG].len);
      end else if (expG >= 0) begin
        locked = expG;
      end
    end
    doReset();
  endtask

  initial begin
    rst_n = 1'b0;
    clearInputs();
    test_reset();
    test_single_ar();
    test_round_robin();
    test_lock();
    test_full();
    test_ordering();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
